// File: rtl/alarm_if.sv
// -----------------------------------------------------------------------------
// alarm_if
// Groups the alarm controller's time inputs, control inputs and status
// outputs into one bundle.
//   master : the side that supplies time and user controls (time counter / UI)
//   slave  : the alarm controller
// Signals:
//   sec_tick            1 Hz strobe, one clk wide; time fields stable while high
//   hour/minute/second  live time of day (11 bit fields)
//   week                live weekday, 1..7 (11 bit field)
//   set_en/set_hour/set_minute  alarm time load request
//   set_week_mask       weekday enable mask (only with ALARM_WEEKDAY_MASK_EN)
//   arm                 level, alarm enabled while high
//   stop/snooze         single-cycle user pulses
//   ringing/snoozed/buzzer  status and tone outputs
//   alarm_hour/alarm_minute stored alarm time
// -----------------------------------------------------------------------------
interface alarm_if;
  logic        sec_tick;
  logic [10:0] hour;
  logic [10:0] minute;
  logic [10:0] second;
  logic [10:0] week;
  logic        set_en;
  logic [4:0]  set_hour;
  logic [5:0]  set_minute;
`ifdef ALARM_WEEKDAY_MASK_EN
  logic [6:0]  set_week_mask;
`endif
  logic        arm;
  logic        stop;
  logic        snooze;
  logic        ringing;
  logic        snoozed;
  logic        buzzer;
  logic [4:0]  alarm_hour;
  logic [5:0]  alarm_minute;

  modport master (
`ifdef ALARM_WEEKDAY_MASK_EN
    output set_week_mask,
`endif
    output sec_tick, hour, minute, second, week,
    output set_en, set_hour, set_minute,
    output arm, stop, snooze,
    input  ringing, snoozed, buzzer, alarm_hour, alarm_minute
  );

  modport slave (
`ifdef ALARM_WEEKDAY_MASK_EN
    input  set_week_mask,
`endif
    input  sec_tick, hour, minute, second, week,
    input  set_en, set_hour, set_minute,
    input  arm, stop, snooze,
    output ringing, snoozed, buzzer, alarm_hour, alarm_minute
  );
endinterface

// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
// Programmable daily alarm fed by the calendar/time counter. A three-state
// FSM (IDLE, RINGING, SNOOZE) rings a square-wave buzzer when the live time
// reaches the stored alarm time at second 0, with stop, snooze and an
// automatic ring timeout. Everything runs on clk; second-level events are
// qualified by sec_tick.
// Parameters:
//   SNOOZE_MIN      snooze length in minutes (1..30)
//   RING_TIMEOUT_S  seconds of ringing before auto-stop (1..255)
//   TONE_DIV        clk cycles per buzzer half-period (>=2)
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  alarm_if.slave: time inputs, set/arm/stop/snooze, status outputs
// Optional feature macro: ALARM_WEEKDAY_MASK_EN adds a per-weekday enable
// mask (set_week_mask, loaded with set_en, resets to all days enabled).
// -----------------------------------------------------------------------------
module alarm_controller #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int TONE_DIV       = 25000
) (
  input  logic   clk,
  input  logic   rst,
  alarm_if.slave bus
);
  localparam int              TW          = $clog2(TONE_DIV);
  localparam logic [TW-1:0]   TONE_LAST   = TW'(TONE_DIV - 1);
  localparam logic [7:0]      RING_LAST   = 8'(RING_TIMEOUT_S - 1);
  localparam logic [10:0]     SNOOZE_LOAD = 11'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      ring_cnt_reg, ring_cnt_next;
  logic [10:0]     snooze_cnt_reg, snooze_cnt_next;
  logic [TW-1:0]   tone_cnt_reg, tone_cnt_next;
  logic            buzzer_reg, buzzer_next;
  logic [4:0]      alarm_hour_reg, alarm_hour_next;
  logic [5:0]      alarm_minute_reg, alarm_minute_next;
  logic            load_ok;
  logic            day_ok;
  logic            match;

  // A load with an out-of-range hour or minute is dropped as a whole.
  assign load_ok = bus.set_en && (bus.set_hour <= 5'd23) && (bus.set_minute <= 6'd59);

`ifdef ALARM_WEEKDAY_MASK_EN
  logic [6:0] week_mask_reg;
  logic [7:0] day_vec;
  // Bit 0 is a hard zero so week==0 never matches; bit n is mask bit n-1.
  assign day_vec = {week_mask_reg, 1'b0};
  assign day_ok  = (bus.week <= 11'd7) && day_vec[bus.week[2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      week_mask_reg <= 7'b1111111;
    end else if (load_ok) begin
      week_mask_reg <= bus.set_week_mask;
    end
  end
`else
  logic unused_week;
  assign unused_week = ^bus.week;
  assign day_ok      = 1'b1;
`endif

  assign match = bus.sec_tick && bus.arm && day_ok &&
                 (bus.hour   == {6'd0, alarm_hour_reg}) &&
                 (bus.minute == {5'd0, alarm_minute_reg}) &&
                 (bus.second == 11'd0);

  always_comb begin
    state_next        = state_reg;
    ring_cnt_next     = ring_cnt_reg;
    snooze_cnt_next   = snooze_cnt_reg;
    tone_cnt_next     = tone_cnt_reg;
    buzzer_next       = buzzer_reg;
    alarm_hour_next   = alarm_hour_reg;
    alarm_minute_next = alarm_minute_reg;

    if (load_ok) begin
      alarm_hour_next   = bus.set_hour;
      alarm_minute_next = bus.set_minute;
    end

    case (state_reg)
      IDLE: begin
        // stop outranks a match arriving in the same cycle.
        if (match && !bus.stop) begin
          state_next    = RINGING;
          ring_cnt_next = '0;
          tone_cnt_next = '0;
          buzzer_next   = 1'b0;
        end
      end
      RINGING: begin
        if (!bus.arm || bus.stop) begin
          state_next  = IDLE;
          buzzer_next = 1'b0;
        end else if (bus.snooze) begin
          state_next      = SNOOZE;
          snooze_cnt_next = SNOOZE_LOAD;
          buzzer_next     = 1'b0;
        end else if (bus.sec_tick && (ring_cnt_reg == RING_LAST)) begin
          // This tick is the RING_TIMEOUT_S-th one counted while ringing.
          state_next  = IDLE;
          buzzer_next = 1'b0;
        end else begin
          if (bus.sec_tick) begin
            ring_cnt_next = ring_cnt_reg + 8'd1;
          end
          if (tone_cnt_reg == TONE_LAST) begin
            tone_cnt_next = '0;
            buzzer_next   = ~buzzer_reg;
          end else begin
            tone_cnt_next = tone_cnt_reg + TW'(1);
          end
        end
      end
      SNOOZE: begin
        if (!bus.arm || bus.stop) begin
          state_next = IDLE;
        end else if (bus.sec_tick) begin
          if (snooze_cnt_reg == 11'd1) begin
            state_next    = RINGING;
            ring_cnt_next = '0;
            tone_cnt_next = '0;
            buzzer_next   = 1'b0;
          end else begin
            snooze_cnt_next = snooze_cnt_reg - 11'd1;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        buzzer_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      ring_cnt_reg     <= '0;
      snooze_cnt_reg   <= '0;
      tone_cnt_reg     <= '0;
      buzzer_reg       <= 1'b0;
      alarm_hour_reg   <= 5'd7;
      alarm_minute_reg <= 6'd0;
    end else begin
      state_reg        <= state_next;
      ring_cnt_reg     <= ring_cnt_next;
      snooze_cnt_reg   <= snooze_cnt_next;
      tone_cnt_reg     <= tone_cnt_next;
      buzzer_reg       <= buzzer_next;
      alarm_hour_reg   <= alarm_hour_next;
      alarm_minute_reg <= alarm_minute_next;
    end
  end

  assign bus.ringing      = (state_reg == RINGING);
  assign bus.snoozed      = (state_reg == SNOOZE);
  assign bus.buzzer       = buzzer_reg;
  assign bus.alarm_hour   = alarm_hour_reg;
  assign bus.alarm_minute = alarm_minute_reg;
endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_controller
// Directed stimulus for alarm_controller with a behavioural model that is
// compared against the outputs every clock, plus literal spot checks.
// -----------------------------------------------------------------------------
module tb_alarm_controller;
  localparam int SNOOZE_MIN     = 5;
  localparam int RING_TIMEOUT_S = 60;
  localparam int TONE_DIV       = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alarm_if bus();

  alarm_controller #(
    .SNOOZE_MIN    (SNOOZE_MIN),
    .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .TONE_DIV      (TONE_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: mode 0 idle, 1 ringing, 2 snoozed.
  int         m_mode = 0;
  int         m_ah = 7, m_am = 0;
  logic [6:0] m_mask = 7'h7F;
  int         m_ring_secs = 0, m_snooze_left = 0, m_ring_cycles = 0;

  int cur_h, cur_m, cur_s;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hit;
    bit day_ok;
    if (rst) begin
      m_mode = 0; m_ah = 7; m_am = 0; m_mask = 7'h7F;
      m_ring_secs = 0; m_snooze_left = 0; m_ring_cycles = 0;
      return;
    end
    day_ok = 1'b1;
`ifdef ALARM_WEEKDAY_MASK_EN
    if (bus.week < 1 || bus.week > 7) day_ok = 1'b0;
    else day_ok = m_mask[int'(bus.week) - 1];
`endif
    hit = bus.sec_tick && bus.arm && day_ok && int'(bus.hour) == m_ah &&
          int'(bus.minute) == m_am && bus.second == 0;
    case (m_mode)
      0: if (hit && !bus.stop) begin
           m_mode = 1; m_ring_secs = 0; m_ring_cycles = 0;
         end
      1: if (!bus.arm || bus.stop) m_mode = 0;
         else if (bus.snooze) begin
           m_mode = 2; m_snooze_left = SNOOZE_MIN * 60;
         end else begin
           if (bus.sec_tick) m_ring_secs++;
           if (m_ring_secs == RING_TIMEOUT_S) m_mode = 0;
           else m_ring_cycles++;
         end
      default: if (!bus.arm || bus.stop) m_mode = 0;
         else if (bus.sec_tick) begin
           m_snooze_left--;
           if (m_snooze_left == 0) begin
             m_mode = 1; m_ring_secs = 0; m_ring_cycles = 0;
           end
         end
    endcase
    if (bus.set_en && bus.set_hour <= 23 && bus.set_minute <= 59) begin
      m_ah = int'(bus.set_hour);
      m_am = int'(bus.set_minute);
`ifdef ALARM_WEEKDAY_MASK_EN
      m_mask = bus.set_week_mask;
`endif
    end
  endtask

  // Model update and full-output comparison once per clock.
  always @(posedge clk) begin
    logic [13:0] exp_v, act_v;
    logic exp_buz;
    model_step();
    #1;
    exp_buz = (m_mode == 1) && (((m_ring_cycles / TONE_DIV) % 2) == 1);
    exp_v = {m_mode == 1, m_mode == 2, exp_buz, 5'(m_ah), 6'(m_am)};
    act_v = {bus.ringing, bus.snoozed, bus.buzzer, bus.alarm_hour, bus.alarm_minute};
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL model_cmp: {ring,snz,buz,hr,min} got %0b_%0b_%0b_%0d_%0d expected %0b_%0b_%0b_%0d_%0d at %0t",
               act_v[13], act_v[12], act_v[11], act_v[10:6], act_v[5:0],
               exp_v[13], exp_v[12], exp_v[11], exp_v[10:6], exp_v[5:0], $time);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    bus.hour = 11'(h); bus.minute = 11'(m); bus.second = 11'(s);
  endtask

  // Advance one second and issue a one-cycle sec_tick; returns at the
  // negedge after the sampling edge.
  task automatic advance();
    cur_s++;
    if (cur_s == 60) begin cur_s = 0; cur_m++; end
    if (cur_m == 60) begin cur_m = 0; cur_h++; end
    if (cur_h == 24) cur_h = 0;
    set_time(cur_h, cur_m, cur_s);
    bus.sec_tick = 1'b1;
    @(negedge clk);
    bus.sec_tick = 1'b0;
  endtask

  task automatic load(input int h, input int m);
    bus.set_en = 1'b1; bus.set_hour = 5'(h); bus.set_minute = 6'(m);
    @(negedge clk);
    bus.set_en = 1'b0;
  endtask

  task automatic pulse(input bit do_stop, input bit do_snooze);
    bus.stop = do_stop; bus.snooze = do_snooze;
    @(negedge clk);
    bus.stop = 1'b0; bus.snooze = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sec_tick = 0; bus.set_en = 0; bus.set_hour = 0; bus.set_minute = 0;
    bus.arm = 0; bus.stop = 0; bus.snooze = 0; bus.week = 11'd1;
`ifdef ALARM_WEEKDAY_MASK_EN
    bus.set_week_mask = 7'h7F;
`endif
    set_time(0, 0, 0);
    cyc(3);
    check("reset_ringing", int'(bus.ringing), 0);
    check("reset_alarm_hour", int'(bus.alarm_hour), 7);
    check("reset_alarm_minute", int'(bus.alarm_minute), 0);
    rst = 1'b0;
    cyc(2);

    // Reset alarm value 07:00 rings when armed.
    bus.arm = 1'b1;
    set_time(6, 59, 59);
    advance();
    check("default_0700_ring", int'(bus.ringing), 1);
    pulse(1'b1, 1'b0);
    check("stop_idle", int'(bus.ringing), 0);

    // Set 06:30 and ring.
    load(6, 30);
    check("load_hour", int'(bus.alarm_hour), 6);
    check("load_minute", int'(bus.alarm_minute), 30);
    set_time(6, 29, 58);
    advance();
    check("no_ring_0629_59", int'(bus.ringing), 0);
    advance();
    check("ring_0630", int'(bus.ringing), 1);
    check("buzzer_entry", int'(bus.buzzer), 0);
    cyc(TONE_DIV - 1);
    check("buzzer_before_toggle", int'(bus.buzzer), 0);
    cyc(1);
    check("buzzer_first_toggle", int'(bus.buzzer), 1);
    cyc(TONE_DIV);
    check("buzzer_second_toggle", int'(bus.buzzer), 0);

    // Timeout after 60 ticks, no re-ring at 06:31.
    for (int i = 1; i <= RING_TIMEOUT_S; i++) begin
      advance();
      if (i == RING_TIMEOUT_S - 1) check("ring_before_timeout", int'(bus.ringing), 1);
      if (i == RING_TIMEOUT_S) check("timeout_idle", int'(bus.ringing), 0);
    end
    repeat (3) advance();
    check("no_rering_0631", int'(bus.ringing), 0);

    // Snooze for 300 ticks.
    set_time(6, 29, 59);
    advance();
    check("ring_before_snooze", int'(bus.ringing), 1);
    cyc(TONE_DIV + 1);
    pulse(1'b0, 1'b1);
    check("snoozed_set", int'(bus.snoozed), 1);
    check("snooze_buzzer_off", int'(bus.buzzer), 0);
    for (int i = 1; i <= SNOOZE_MIN * 60; i++) begin
      advance();
      if (i == SNOOZE_MIN * 60 - 1) check("still_snoozed", int'(bus.snoozed), 1);
      if (i == SNOOZE_MIN * 60) begin
        check("rering_after_snooze", int'(bus.ringing), 1);
        check("snoozed_cleared", int'(bus.snoozed), 0);
      end
    end

    // stop and snooze together: stop wins.
    cyc(TONE_DIV + 1);
    pulse(1'b1, 1'b1);
    check("stop_snooze_ringing", int'(bus.ringing), 0);
    check("stop_snooze_snoozed", int'(bus.snoozed), 0);
    check("stop_snooze_buzzer", int'(bus.buzzer), 0);
    repeat (3) advance();

    // Stop within the matching minute: no re-ring.
    set_time(6, 29, 59);
    advance();
    advance();
    pulse(1'b1, 1'b0);
    repeat (3) advance();
    check("no_retrigger", int'(bus.ringing), 0);

    // Invalid and boundary loads.
    load(24, 10);
    check("bad_hour_keep_h", int'(bus.alarm_hour), 6);
    check("bad_hour_keep_m", int'(bus.alarm_minute), 30);
    load(12, 60);
    check("bad_min_keep_h", int'(bus.alarm_hour), 6);
    load(23, 59);
    check("load_2359_h", int'(bus.alarm_hour), 23);
    check("load_2359_m", int'(bus.alarm_minute), 59);
    load(6, 30);

    // arm low blocks a match and aborts a ring.
    bus.arm = 1'b0;
    set_time(6, 29, 59);
    advance();
    check("disarmed_no_ring", int'(bus.ringing), 0);
    bus.arm = 1'b1;
    set_time(6, 29, 59);
    advance();
    check("armed_ring", int'(bus.ringing), 1);
    bus.arm = 1'b0;
    cyc(1);
    check("disarm_stops", int'(bus.ringing), 0);
    bus.arm = 1'b1;

    // Asynchronous reset mid-ring.
    set_time(6, 29, 59);
    advance();
    cyc(TONE_DIV);
    check("pre_rst_buzzer", int'(bus.buzzer), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ringing", int'(bus.ringing), 0);
    check("async_rst_buzzer", int'(bus.buzzer), 0);
    check("async_rst_hour", int'(bus.alarm_hour), 7);
    check("async_rst_minute", int'(bus.alarm_minute), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);

`ifdef ALARM_WEEKDAY_MASK_EN
    bus.set_week_mask = 7'b0011111;
    load(7, 0);
    bus.week = 11'd6;
    set_time(6, 59, 59);
    advance();
    check("mask_week6_no_ring", int'(bus.ringing), 0);
    bus.week = 11'd5;
    set_time(6, 59, 59);
    advance();
    check("mask_week5_ring", int'(bus.ringing), 1);
    pulse(1'b1, 1'b0);
    bus.week = 11'd0;
    set_time(6, 59, 59);
    advance();
    check("mask_week0_no_ring", int'(bus.ringing), 0);
`endif

    cyc(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
